// File: rtl/serdes8_link.sv
// Framed 8-bit serial link: start '1', D7..D0, stop '0', OVS clocks per bit.
// Parallel-to-serial transmitter and oversampling receiver sharing clock_ser.
module serdes8_link #(
    parameter int OVS = 4
) (
    input  logic       clock_ser,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic       ser_out,
    output logic       busy,
    input  logic       des_enable,
    input  logic       des_in,
    output logic [7:0] data_out,
    output logic       data_valid
);

    localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [CW-1:0] SUB_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] SUB_PRE   = CW'(OVS - 2);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);

    if (OVS != 1 && OVS != 2 && OVS != 4 && OVS != 8 && OVS != 16) begin : g_ovs_illegal
        $error("serdes8_link: OVS must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_CHECK, RX_DATA, RX_WAIT_IDLE} rx_state_t;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_sub;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shreg;

    rx_state_t       rx_state;
    logic [CW-1:0]   rx_sub;
    logic [2:0]      rx_bit;
    logic [6:0]      rx_shreg;
    logic            des_q;

    // Transmitter: a load is accepted whenever busy is low, including the last
    // STOP clock, which is what makes back-to-back frames seamless.
    always_ff @(posedge clock_ser or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_sub   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            ser_out  <= 1'b0;
            busy     <= 1'b0;
        end else if (enable && !busy) begin
            tx_state <= TX_START;
            tx_sub   <= '0;
            tx_bit   <= '0;
            tx_shreg <= data_in;
            ser_out  <= 1'b1;
            busy     <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    ser_out <= 1'b0;
                end
                TX_START: begin
                    if (tx_sub == SUB_LAST) begin
                        tx_sub   <= '0;
                        tx_state <= TX_DATA;
                        ser_out  <= tx_shreg[7];
                    end else begin
                        tx_sub <= tx_sub + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_sub == SUB_LAST) begin
                        tx_sub <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            ser_out  <= 1'b0;
                            // With one clock per bit the stop bit is itself the last clock
                            if (OVS == 1) busy <= 1'b0;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shreg <= {tx_shreg[6:0], 1'b0};
                            ser_out  <= tx_shreg[6];
                        end
                    end else begin
                        tx_sub <= tx_sub + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_sub == SUB_LAST) begin
                        tx_sub   <= '0;
                        tx_state <= TX_IDLE;
                        ser_out  <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        if (tx_sub == SUB_PRE) busy <= 1'b0;
                        tx_sub <= tx_sub + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Receiver: CHECK re-samples mid start bit, so each data sample then lands
    // mid-bit when taken every OVS clocks.
    always_ff @(posedge clock_ser or posedge reset) begin
        if (reset) begin
            des_q      <= 1'b0;
            rx_state   <= RX_HUNT;
            rx_sub     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            des_q      <= des_in;
            data_valid <= 1'b0;
            if (!des_enable) begin
                rx_state <= RX_HUNT;
                rx_sub   <= '0;
                rx_bit   <= '0;
            end else begin
                case (rx_state)
                    RX_HUNT: begin
                        if (des_q) begin
                            rx_sub   <= '0;
                            rx_bit   <= '0;
                            rx_state <= (OVS == 1) ? RX_DATA : RX_CHECK;
                        end
                    end
                    RX_CHECK: begin
                        if (rx_sub == HALF_LAST) begin
                            rx_sub   <= '0;
                            rx_state <= des_q ? RX_DATA : RX_HUNT;
                        end else begin
                            rx_sub <= rx_sub + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_sub == SUB_LAST) begin
                            rx_sub   <= '0;
                            rx_bit   <= rx_bit + 1'b1;
                            rx_shreg <= {rx_shreg[5:0], des_q};
                            if (rx_bit == 3'd7) begin
                                data_out   <= {rx_shreg, des_q};
                                data_valid <= 1'b1;
                                rx_state   <= RX_WAIT_IDLE;
                            end
                        end else begin
                            rx_sub <= rx_sub + 1'b1;
                        end
                    end
                    RX_WAIT_IDLE: begin
                        // A trailing D0=1 must not be mistaken for a start bit
                        if (!des_q) rx_state <= RX_HUNT;
                    end
                    default: begin
                        rx_state <= RX_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serdes8_link.sv
// Bench for serdes8_link: OVS=1 and OVS=4 instances in loopback, with a
// scoreboard of expected received bytes per instance.
module tb_serdes8_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en1, en4;
    logic [7:0] din1, din4;
    logic       so1, so4, busy1, busy4;
    logic       den1, den4;
    logic [7:0] dout1, dout4;
    logic       dv1, dv4;
    logic       lb4, force4;
    logic       des4;

    assign des4 = lb4 ? so4 : force4;

    serdes8_link #(.OVS(1)) u_ovs1 (
        .clock_ser (clk),
        .reset     (reset),
        .enable    (en1),
        .data_in   (din1),
        .ser_out   (so1),
        .busy      (busy1),
        .des_enable(den1),
        .des_in    (so1),
        .data_out  (dout1),
        .data_valid(dv1)
    );

    serdes8_link #(.OVS(4)) u_ovs4 (
        .clock_ser (clk),
        .reset     (reset),
        .enable    (en4),
        .data_in   (din4),
        .ser_out   (so4),
        .busy      (busy4),
        .des_enable(den4),
        .des_in    (des4),
        .data_out  (dout4),
        .data_valid(dv4)
    );

    int checks = 0;
    int errors = 0;
    int rx1_cnt = 0;
    int rx4_cnt = 0;
    int cyc = 0;
    int dv4_cyc = -1;
    logic [7:0] q1[$];
    logic [7:0] q4[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b1;
        if (k == 9) return 1'b0;
        return b[8-k];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (dv1) begin
                rx1_cnt++;
                check_val("rx1_pending", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) check_val("rx1_byte", 32'(dout1), 32'(q1.pop_front()));
            end
            if (dv4) begin
                rx4_cnt++;
                dv4_cyc = cyc;
                check_val("rx4_pending", 32'(q4.size() != 0), 1);
                if (q4.size() != 0) check_val("rx4_byte", 32'(dout4), 32'(q4.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] seq [3];
        int base;
        int load_cyc;
        int lat;
        seq[0] = 8'hAB; seq[1] = 8'hEB; seq[2] = 8'hCF;

        reset = 1'b1; en1 = 1'b0; en4 = 1'b0; din1 = '0; din4 = '0;
        den1 = 1'b1; den4 = 1'b1; lb4 = 1'b1; force4 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_so1", 32'(so1), 0);
        check_val("rst_busy1", 32'(busy1), 0);
        check_val("rst_dout1", 32'(dout1), 0);
        check_val("rst_dv1", 32'(dv1), 0);
        check_val("rst_so4", 32'(so4), 0);
        check_val("rst_busy4", 32'(busy4), 0);
        check_val("rst_dout4", 32'(dout4), 0);
        check_val("rst_dv4", 32'(dv4), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of an OVS=4 frame
        din4 = 8'h96; en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        repeat (14) @(negedge clk);
        check_val("midframe_busy4", 32'(busy4), 1);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_so4", 32'(so4), 0);
        check_val("midrst_busy4", 32'(busy4), 0);
        check_val("midrst_dout4", 32'(dout4), 0);
        check_val("midrst_dv4", 32'(dv4), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check_val("postrst_so4", 32'(so4), 0);
        check_val("postrst_busy4", 32'(busy4), 0);
        check_val("postrst_rx4_cnt", rx4_cnt, 0);

        // OVS=1 loopback of 8'hAB
        din1 = 8'hAB; en1 = 1'b1; q1.push_back(8'hAB);
        @(negedge clk);
        en1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k < 10) check_val($sformatf("ovs1_bit%0d", k), 32'(so1), 32'(frame_bit(8'hAB, k)));
            check_val($sformatf("ovs1_dv_k%0d", k), 32'(dv1), 32'(k == 10));
            @(negedge clk);
        end
        check_val("ovs1_rx_cnt", rx1_cnt, 1);

        // OVS=4 loopback, three frames 10 bit periods apart
        base = rx4_cnt;
        for (int i = 0; i < 3; i++) begin
            din4 = seq[i]; en4 = 1'b1; q4.push_back(seq[i]);
            load_cyc = cyc + 1;
            @(negedge clk);
            en4 = 1'b0;
            repeat (39) @(negedge clk);
            if (i == 0) begin
                lat = dv4_cyc - load_cyc;
                check_val("ovs4_latency_in_bound", 32'(lat > 0 && lat <= 40), 1);
            end
        end
        repeat (10) @(negedge clk);
        check_val("ovs4_seq_cnt", rx4_cnt - base, 3);

        // Held enable with 8'hFF: three back-to-back frames
        base = rx4_cnt;
        din4 = 8'hFF; en4 = 1'b1;
        repeat (3) q4.push_back(8'hFF);
        @(negedge clk);
        for (int k = 0; k < 120; k++) begin
            check_val($sformatf("held_bit_k%0d", k), 32'(so4), 32'(frame_bit(8'hFF, (k / 4) % 10)));
            check_val($sformatf("held_busy_k%0d", k), 32'(busy4), 32'((k % 40) != 39));
            if (k == 80) en4 = 1'b0;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_val("held_rx_cnt", rx4_cnt - base, 3);
        check_val("held_idle_so4", 32'(so4), 0);

        // Load while busy is ignored, as are later data_in changes
        base = rx4_cnt;
        din4 = 8'h3C; en4 = 1'b1; q4.push_back(8'h3C);
        @(negedge clk);
        en4 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) begin en4 = 1'b1; din4 = 8'hC3; end
            if (k == 11) en4 = 1'b0;
            check_val($sformatf("busyload_bit_k%0d", k), 32'(so4), 32'(frame_bit(8'h3C, k / 4)));
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_val("busyload_rx_cnt", rx4_cnt - base, 1);
        check_val("busyload_dout4", 32'(dout4), 'h3C);
        check_val("busyload_idle_busy4", 32'(busy4), 0);

        // One-clock glitch on the line
        base = rx4_cnt;
        lb4 = 1'b0; force4 = 1'b0;
        repeat (5) @(negedge clk);
        force4 = 1'b1;
        @(negedge clk);
        force4 = 1'b0;
        repeat (60) @(negedge clk);
        check_val("glitch_rx_cnt", rx4_cnt - base, 0);
        check_val("glitch_dout4", 32'(dout4), 'h3C);

        // des_enable dropped mid-byte
        base = rx4_cnt;
        lb4 = 1'b1;
        din4 = 8'h5A; en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        repeat (16) @(negedge clk);
        den4 = 1'b0;
        repeat (30) @(negedge clk);
        den4 = 1'b1;
        repeat (10) @(negedge clk);
        check_val("desen_rx_cnt", rx4_cnt - base, 0);
        check_val("desen_dout4", 32'(dout4), 'h3C);
        check_val("desen_dv4", 32'(dv4), 0);

        check_val("q1_drained", q1.size(), 0);
        check_val("q4_drained", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
